// File: rtl/uart_frame_core_pkg.sv
// Shared types, state encodings and RX flag positions for the UART frame engine.
package uart_frame_core_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam int unsigned RxWidth  = 11;
    localparam int unsigned FlagPerr = 8;
    localparam int unsigned FlagFerr = 9;
    localparam int unsigned FlagBrk  = 10;

    function automatic parity_e decode_parity(input logic [1:0] code);
        case (code)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        case (dbits)
            2'd0:    return 8'h1f;
            2'd1:    return 8'h3f;
            2'd2:    return 8'h7f;
            default: return 8'hff;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_core_if.sv
// Byte-stream handshakes between the register shell (master) and the UART core (slave).
interface uart_frame_core_if;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [10:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;

    modport master (output tx_tdata, tx_tvalid, rx_tready,
                    input  tx_tready, rx_tdata, rx_tvalid);
    modport slave  (input  tx_tdata, tx_tvalid, rx_tready,
                    output tx_tready, rx_tdata, rx_tvalid);
endinterface

// File: rtl/uart_frame_core_sync_fifo.sv
// Synchronous FIFO with occupancy output; a pop frees space for a same-cycle push when full.
module uart_frame_core_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_frame_core.sv
// UART TX/RX engine: runtime frame format, 16x oversampling, RX FIFO with error tags, RTS/CTS.
module uart_frame_core
    import uart_frame_core_pkg::*;
#(
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned RTS_MARGIN = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [15:0]               cfg_div,
    input  logic [1:0]                cfg_dbits,
    input  logic [1:0]                cfg_parity,
    input  logic                      cfg_stop2,
    input  logic                      cfg_flow_en,
    uart_frame_core_if.slave          bus,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic                      rx_overrun,
    input  logic                      ovr_clr,
    output logic                      tx_busy,
    output logic                      uart_tx,
    input  logic                      uart_rx,
    output logic                      uart_rts_n,
    input  logic                      uart_cts_n
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned LvlW = $clog2(RX_DEPTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);

    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick;
    logic [1:0]  rx_sync_q, cts_sync_q;
    logic        rx_prev_q, rx_s, cts_s;

    logic [2:0]      tx_st_q, tx_st_d, tx_bit_q, tx_bit_d, tx_last_q, tx_last_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d, hold_q;
    logic            tx_par_q, tx_par_d, tx_paren_q, tx_paren_d, tx_stop2_q, tx_stop2_d;
    logic            hold_full_q, tx_q, tx_line, tx_accept, tx_bit_end, tx_load, tx_frame_done;
    logic [7:0]      load_data;
    parity_e         load_par;

    logic [2:0]      rx_st_q, rx_st_d, rx_bit_q, rx_bit_d, rx_last_q, rx_last_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    parity_e         rx_par_q, rx_par_d;
    logic            rx_pbit_q, rx_pbit_d, rx_sample, rx_bit_end, rx_push;
    logic            perr, ferr, brk, fifo_full, fifo_empty, rx_pop, ovr_q, rts_q;
    logic [RxWidth-1:0] rx_word, fifo_rdata;

    assign tick       = (tick_cnt_q == '0);
    assign tick_cnt_d = tick ? ((cfg_div == '0) ? 16'd0 : cfg_div - 16'd1) : tick_cnt_q - 16'd1;
    assign rx_s       = rx_sync_q[1];
    assign cts_s      = cts_sync_q[1];

    // ---------------- Transmit ----------------
    assign tx_accept     = bus.tx_tvalid & ~hold_full_q;
    assign tx_bit_end    = tick & (tx_cnt_q == CntLast) & (tx_st_q != StIdle);
    assign tx_frame_done = (tx_st_q == StStop) & tx_bit_end & (~tx_stop2_q | tx_bit_q[0]);
    // CTS only gates the start of a frame; a frame in flight always completes.
    assign tx_load   = tick & hold_full_q & (~cfg_flow_en | ~cts_s) &
                       ((tx_st_q == StIdle) | tx_frame_done);
    assign load_data = hold_q & data_mask(cfg_dbits);
    assign load_par  = decode_parity(cfg_parity);

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_par_d   = tx_par_q;
        tx_last_d  = tx_last_q;
        tx_paren_d = tx_paren_q;
        tx_stop2_d = tx_stop2_q;
        if (tick && tx_st_q != StIdle) tx_cnt_d = tx_cnt_q + CntW'(1);
        if (tx_bit_end) begin
            case (tx_st_q)
                StStart:  begin tx_st_d = StData; tx_bit_d = '0; end
                StData: begin
                    if (tx_bit_q == tx_last_q) begin
                        tx_st_d  = tx_paren_q ? StParity : StStop;
                        tx_bit_d = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
                StParity: begin tx_st_d = StStop; tx_bit_d = '0; end
                default: begin
                    if (tx_frame_done) tx_st_d = StIdle;
                    else               tx_bit_d = 3'd1;
                end
            endcase
        end
        if (tx_load) begin
            tx_st_d    = StStart;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_data_d  = load_data;
            tx_last_d  = {1'b1, cfg_dbits};
            tx_paren_d = (load_par != PAR_NONE);
            tx_par_d   = (load_par == PAR_ODD) ? ~^load_data : ^load_data;
            tx_stop2_d = cfg_stop2;
        end
    end

    always_comb begin
        case (tx_st_q)
            StStart:  tx_line = 1'b0;
            StData:   tx_line = tx_data_q[tx_bit_q];
            StParity: tx_line = tx_par_q;
            default:  tx_line = 1'b1;
        endcase
    end

    // ---------------- Receive ----------------
    assign rx_sample  = tick & (rx_cnt_q == CntMid);
    assign rx_bit_end = tick & (rx_cnt_q == CntLast);
    assign rx_push    = (rx_st_q == StStop) & rx_sample;
    assign perr = ((rx_par_q == PAR_EVEN) & (^rx_data_q != rx_pbit_q)) |
                  ((rx_par_q == PAR_ODD) & (~^rx_data_q != rx_pbit_q));
    assign ferr = ~rx_s;
    assign brk  = (rx_data_q == '0) & ((rx_par_q == PAR_NONE) | ~rx_pbit_q) & ~rx_s;

    always_comb begin
        rx_word           = '0;
        rx_word[7:0]      = rx_data_q;
        rx_word[FlagPerr] = perr;
        rx_word[FlagFerr] = ferr;
        rx_word[FlagBrk]  = brk;
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_data_d = rx_data_q;
        rx_par_d  = rx_par_q;
        rx_last_d = rx_last_q;
        rx_pbit_d = rx_pbit_q;
        if (rx_st_q == StIdle) begin
            // Edge-triggered start: a line still low after a break cannot re-trigger.
            if (rx_prev_q && !rx_s) begin
                rx_st_d   = StStart;
                rx_cnt_d  = '0;
                rx_bit_d  = '0;
                rx_data_d = '0;
                rx_pbit_d = 1'b0;
                rx_par_d  = decode_parity(cfg_parity);
                rx_last_d = {1'b1, cfg_dbits};
            end
        end else begin
            if (tick) rx_cnt_d = rx_cnt_q + CntW'(1);
            case (rx_st_q)
                StStart: begin
                    if (rx_sample && rx_s) rx_st_d = StIdle;
                    else if (rx_bit_end)   rx_st_d = StData;
                end
                StData: begin
                    if (rx_sample) rx_data_d[rx_bit_q] = rx_s;
                    if (rx_bit_end) begin
                        if (rx_bit_q == rx_last_q)
                            rx_st_d = (rx_par_q == PAR_NONE) ? StStop : StParity;
                        else
                            rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
                StParity: begin
                    if (rx_sample)  rx_pbit_d = rx_s;
                    if (rx_bit_end) rx_st_d = StStop;
                end
                default: if (rx_sample) rx_st_d = StIdle;
            endcase
        end
    end

    assign rx_pop = ~fifo_empty & bus.rx_tready;

    uart_frame_core_sync_fifo #(
        .WIDTH (RxWidth),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (rx_push),
        .wdata_i (rx_word),
        .pop_i   (bus.rx_tready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (rx_level)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            tick_cnt_q  <= '0;
            rx_sync_q   <= '1;
            cts_sync_q  <= '1;
            rx_prev_q   <= 1'b1;
            tx_st_q     <= StIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            tx_par_q    <= 1'b0;
            tx_last_q   <= '0;
            tx_paren_q  <= 1'b0;
            tx_stop2_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            rx_st_q     <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_data_q   <= '0;
            rx_par_q    <= PAR_NONE;
            rx_last_q   <= '0;
            rx_pbit_q   <= 1'b0;
            ovr_q       <= 1'b0;
            rts_q       <= 1'b1;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            rx_sync_q   <= {rx_sync_q[0], uart_rx};
            cts_sync_q  <= {cts_sync_q[0], uart_cts_n};
            rx_prev_q   <= rx_s;
            tx_st_q     <= tx_st_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_par_q    <= tx_par_d;
            tx_last_q   <= tx_last_d;
            tx_paren_q  <= tx_paren_d;
            tx_stop2_q  <= tx_stop2_d;
            if (tx_accept) hold_q <= bus.tx_tdata;
            hold_full_q <= tx_accept | (hold_full_q & ~tx_load);
            tx_q        <= tx_line;
            rx_st_q     <= rx_st_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_data_q   <= rx_data_d;
            rx_par_q    <= rx_par_d;
            rx_last_q   <= rx_last_d;
            rx_pbit_q   <= rx_pbit_d;
            ovr_q       <= ~ovr_clr & (ovr_q | (rx_push & fifo_full & ~rx_pop));
            rts_q       <= cfg_flow_en & (rx_level >= LvlW'(RX_DEPTH - RTS_MARGIN));
        end
    end

    assign bus.tx_tready = ~hold_full_q;
    assign bus.rx_tvalid = ~fifo_empty;
    assign bus.rx_tdata  = fifo_rdata;
    assign rx_overrun    = ovr_q;
    assign tx_busy       = hold_full_q | (tx_st_q != StIdle);
    assign uart_tx       = tx_q;
    assign uart_rts_n    = rts_q;
endmodule

// File: tb/tb_uart_frame_core.sv
// Directed bench for uart_frame_core at 10 MHz with cfg_div=5 (80 clocks per bit).
`timescale 1ns/1ps
module tb_uart_frame_core;
    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dbits, cfg_parity;
    logic        cfg_stop2, cfg_flow_en, ovr_clr;
    logic [4:0]  rx_level;
    logic        rx_overrun, tx_busy, uart_tx, uart_rx, uart_rts_n, uart_cts_n;
    int          n_cmp = 0;
    int          n_err = 0;

    uart_frame_core_if bus ();

    uart_frame_core #(.RX_DEPTH(16), .RTS_MARGIN(4), .OVERSAMPLE(16)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cfg_div     (cfg_div),
        .cfg_dbits   (cfg_dbits),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .cfg_flow_en (cfg_flow_en),
        .bus         (bus),
        .rx_level    (rx_level),
        .rx_overrun  (rx_overrun),
        .ovr_clr     (ovr_clr),
        .tx_busy     (tx_busy),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .uart_rts_n  (uart_rts_n),
        .uart_cts_n  (uart_cts_n)
    );

    always #50 aclk = ~aclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx_fall(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge aclk);
            if (uart_tx == 1'b0) ok = 1'b1;
        end
    endtask

    // Called on the first sample with uart_tx low; checks an 8N1 frame at bit centres.
    task automatic check_tx_frame(input logic [7:0] b);
        repeat (40) @(negedge aclk);
        check("tx_start_bit", 16'(uart_tx), 16'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (80) @(negedge aclk);
            check($sformatf("tx_data_bit%0d", i), 16'(uart_tx), 16'(b[i]));
        end
        repeat (80) @(negedge aclk);
        check("tx_stop_bit", 16'(uart_tx), 16'h1);
    endtask

    task automatic send_rx(input logic [15:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            uart_rx = f[i];
            repeat (80) @(negedge aclk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_tx_byte(input logic [7:0] b);
        bus.tx_tdata  = b;
        bus.tx_tvalid = 1'b1;
        @(negedge aclk);
        bus.tx_tvalid = 1'b0;
    endtask

    task automatic pop_rx();
        bus.rx_tready = 1'b1;
        @(negedge aclk);
        bus.rx_tready = 1'b0;
    endtask

    task automatic count_tx_lows(input int ncyc, output int lows);
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge aclk);
            if (uart_tx == 1'b0) lows++;
        end
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          lows;
        logic [15:0] f;
        logic [7:0]  d;

        areset = 1'b1; cfg_div = 16'd5; cfg_dbits = 2'd3; cfg_parity = 2'd0;
        cfg_stop2 = 1'b0; cfg_flow_en = 1'b0; ovr_clr = 1'b0;
        uart_rx = 1'b1; uart_cts_n = 1'b0;
        bus.tx_tdata = '0; bus.tx_tvalid = 1'b0; bus.rx_tready = 1'b0;
        repeat (5) @(negedge aclk);
        check("rst_uart_tx", 16'(uart_tx), 16'h1);
        check("rst_rts_n", 16'(uart_rts_n), 16'h1);
        check("rst_tx_tready", 16'(bus.tx_tready), 16'h1);
        check("rst_rx_tvalid", 16'(bus.rx_tvalid), 16'h0);
        check("rst_rx_level", 16'(rx_level), 16'h0);
        check("rst_overrun", 16'(rx_overrun), 16'h0);
        check("rst_tx_busy", 16'(tx_busy), 16'h0);
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        check("rts_n_flow_off", 16'(uart_rts_n), 16'h0);

        // TX 8N1 0xA5
        send_tx_byte(8'hA5);
        check("tx_tready_full", 16'(bus.tx_tready), 16'h0);
        wait_tx_fall(200, ok);
        check("tx_a5_started", 16'(ok), 16'h1);
        check("tx_tready_back", 16'(bus.tx_tready), 16'h1);
        check_tx_frame(8'hA5);
        repeat (30) @(negedge aclk);
        check("tx_busy_in_frame", 16'(tx_busy), 16'h1);
        repeat (20) @(negedge aclk);
        check("tx_busy_after_frame", 16'(tx_busy), 16'h0);

        // RX 7E2, 0x35 with correct then wrong parity
        cfg_dbits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
        f = {5'h1f, 2'b11, 1'b0, 7'h35, 1'b0};
        send_rx(f, 11);
        repeat (20) @(negedge aclk);
        check("rx_7e2_valid", 16'(bus.rx_tvalid), 16'h1);
        check("rx_7e2_data", 16'(bus.rx_tdata), 16'h035);
        pop_rx();
        check("rx_level_after_pop", 16'(rx_level), 16'h0);
        f = {5'h1f, 2'b11, 1'b1, 7'h35, 1'b0};
        send_rx(f, 11);
        repeat (20) @(negedge aclk);
        check("rx_parity_err", 16'(bus.rx_tdata), 16'h135);
        pop_rx();

        // Break on 8N1
        cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        uart_rx = 1'b0;
        repeat (12 * 80) @(negedge aclk);
        check("brk_level", 16'(rx_level), 16'h1);
        check("brk_data", 16'(bus.rx_tdata), 16'h600);
        repeat (4 * 80) @(negedge aclk);
        check("brk_no_repeat_low", 16'(rx_level), 16'h1);
        uart_rx = 1'b1;
        repeat (160) @(negedge aclk);
        check("brk_no_repeat_high", 16'(rx_level), 16'h1);
        pop_rx();

        // 3-clock glitch is a false start
        uart_rx = 1'b0;
        repeat (3) @(negedge aclk);
        uart_rx = 1'b1;
        repeat (200) @(negedge aclk);
        check("glitch_no_entry", 16'(rx_level), 16'h0);

        // Fill FIFO with flow control on
        cfg_flow_en = 1'b1;
        repeat (3) @(negedge aclk);
        check("rts_n_empty", 16'(uart_rts_n), 16'h0);
        for (int i = 0; i < 16; i++) begin
            d = 8'h10 + 8'(i);
            f = {6'h3f, 1'b1, d, 1'b0};
            send_rx(f, 10);
            if (i == 10) check("rts_n_level11", 16'(uart_rts_n), 16'h0);
            if (i == 11) check("rts_n_level12", 16'(uart_rts_n), 16'h1);
        end
        check("fill_level16", 16'(rx_level), 16'h10);
        check("fill_no_overrun", 16'(rx_overrun), 16'h0);
        f = {6'h3f, 1'b1, 8'hEE, 1'b0};
        send_rx(f, 10);
        check("overrun_set", 16'(rx_overrun), 16'h1);
        check("overrun_level", 16'(rx_level), 16'h10);
        ovr_clr = 1'b1;
        @(negedge aclk);
        ovr_clr = 1'b0;
        check("overrun_clr", 16'(rx_overrun), 16'h0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 16'(bus.rx_tdata), 16'h10 + 16'(i));
            pop_rx();
        end
        check("drain_level", 16'(rx_level), 16'h0);
        repeat (2) @(negedge aclk);
        check("rts_n_drained", 16'(uart_rts_n), 16'h0);

        // CTS gating: held off until cts_n low, never aborted once started
        uart_cts_n = 1'b1;
        repeat (5) @(negedge aclk);
        send_tx_byte(8'h41);
        count_tx_lows(1600, lows);
        check("cts_hold_off", 16'(lows), 16'h0);
        check("cts_busy_waiting", 16'(tx_busy), 16'h1);
        uart_cts_n = 1'b0;
        wait_tx_fall(200, ok);
        check("cts_release_start", 16'(ok), 16'h1);
        uart_cts_n = 1'b1;
        check_tx_frame(8'h41);
        uart_cts_n = 1'b0;
        repeat (100) @(negedge aclk);

        // Reset during data bit 3 of 0xA5 with a second byte queued
        cfg_flow_en = 1'b0;
        send_tx_byte(8'hA5);
        wait_tx_fall(200, ok);
        check("rst_tx_started", 16'(ok), 16'h1);
        send_tx_byte(8'h3C);
        check("rst_hold_full", 16'(bus.tx_tready), 16'h0);
        repeat (359) @(negedge aclk);
        check("rst_mid_bit3", 16'(uart_tx), 16'h0);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        check("rst_abort_tx", 16'(uart_tx), 16'h1);
        check("rst_abort_tready", 16'(bus.tx_tready), 16'h1);
        check("rst_abort_busy", 16'(tx_busy), 16'h0);
        count_tx_lows(1000, lows);
        check("rst_line_idle", 16'(lows), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
